// File: rtl/mem_access_stage.sv
// MEM-stage access unit: data-memory drive, load lane select/extension,
// misalignment detection with address-error reporting, and the MEM/WB register.
module mem_access_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        interupt,
    input  logic [3:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [31:0] pc,
    input  logic [4:0]  rd_idx,
    input  logic        reg_we,
    output logic [29:0] dm_A,
    output logic [31:0] dm_WD,
    output logic        dm_we,
    output logic [3:0]  dm_BE,
    input  logic [31:0] dm_RD,
    output logic        wb_valid,
    output logic [4:0]  wb_rd_idx,
    output logic        wb_reg_we,
    output logic [31:0] wb_data,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic [31:0] exc_pc,
    output logic [31:0] bad_vaddr
);

    localparam logic [3:0] OP_LW  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LB  = 4'd4;
    localparam logic [3:0] OP_LBU = 4'd5;
    localparam logic [3:0] OP_SW  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9;
    localparam logic [3:0] OP_SB  = 4'd10;

    function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
        logic signed [15:0] hs;
        logic signed [31:0] hx;
        hs = h;
        hx = 32'(hs);
        return sgn ? hx : {16'h0000, h};
    endfunction

    function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
        logic signed [7:0]  bs;
        logic signed [31:0] bx;
        bs = b;
        bx = 32'(bs);
        return sgn ? bx : {24'h000000, b};
    endfunction

    logic [1:0]  w_off;
    logic        w_is_ld;
    logic        w_is_st;
    logic        w_misal;
    logic [3:0]  w_be;
    logic [15:0] w_half;
    logic [7:0]  w_byte;
    logic [31:0] w_ld_data;
    logic [31:0] w_wb_data;
    logic        w_squash;
    logic        w_rec;

    logic        r_wb_valid_p1;
    logic [4:0]  r_wb_rd_idx_p1;
    logic        r_wb_reg_we_p1;
    logic [31:0] r_wb_data_p1;
    logic        r_exc_adel_p1;
    logic        r_exc_ades_p1;
    logic [31:0] r_exc_pc_p1;
    logic [31:0] r_bad_vaddr_p1;

    assign w_off = addr[1:0];

    always_comb begin
        w_is_ld = 1'b0;
        w_is_st = 1'b0;
        w_misal = 1'b0;
        w_be    = 4'b0000;
        unique case (mem_op)
            OP_LW: begin
                w_is_ld = 1'b1;
                w_misal = (w_off != 2'd0);
            end
            OP_LH, OP_LHU: begin
                w_is_ld = 1'b1;
                w_misal = w_off[0];
            end
            OP_LB, OP_LBU: w_is_ld = 1'b1;
            OP_SW: begin
                w_is_st = 1'b1;
                w_misal = (w_off != 2'd0);
                w_be    = w_misal ? 4'b0000 : 4'b1111;
            end
            OP_SH: begin
                w_is_st = 1'b1;
                w_misal = w_off[0];
                w_be    = w_misal ? 4'b0000 : (w_off[1] ? 4'b1100 : 4'b0011);
            end
            OP_SB: begin
                w_is_st = 1'b1;
                case (w_off)
                    2'd0:    w_be = 4'b0001;
                    2'd1:    w_be = 4'b0010;
                    2'd2:    w_be = 4'b0100;
                    default: w_be = 4'b1000;
                endcase
            end
            default: ;
        endcase
    end

    // Memory side: combinational so a store commits at the edge the instruction leaves MEM.
    assign dm_A  = addr[31:2];
    assign dm_WD = store_data;
    assign dm_BE = w_be;
    assign dm_we = w_is_st & ~w_misal & ~stall & ~flush & ~interupt;

    always_comb begin
        w_half = w_off[1] ? dm_RD[31:16] : dm_RD[15:0];
        case (w_off)
            2'd0:    w_byte = dm_RD[7:0];
            2'd1:    w_byte = dm_RD[15:8];
            2'd2:    w_byte = dm_RD[23:16];
            default: w_byte = dm_RD[31:24];
        endcase
        case (mem_op)
            OP_LW:   w_ld_data = dm_RD;
            OP_LH:   w_ld_data = ext_half(w_half, 1'b1);
            OP_LHU:  w_ld_data = ext_half(w_half, 1'b0);
            OP_LB:   w_ld_data = ext_byte(w_byte, 1'b1);
            OP_LBU:  w_ld_data = ext_byte(w_byte, 1'b0);
            default: w_ld_data = addr;
        endcase
        w_wb_data = w_is_ld ? w_ld_data : addr;
    end

    assign w_squash = flush | interupt | w_misal;
    // A stalled faulting instruction is recorded only once it is free to leave MEM.
    assign w_rec    = w_misal & ~flush & ~interupt & ~stall;

    // MEM -> WB boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_valid_p1  <= 1'b0;
            r_wb_rd_idx_p1 <= 5'd0;
            r_wb_reg_we_p1 <= 1'b0;
            r_wb_data_p1   <= 32'd0;
            r_exc_adel_p1  <= 1'b0;
            r_exc_ades_p1  <= 1'b0;
            r_exc_pc_p1    <= 32'd0;
            r_bad_vaddr_p1 <= 32'd0;
        end else begin
            if (w_squash) begin
                r_wb_valid_p1  <= 1'b0;
                r_wb_reg_we_p1 <= 1'b0;
            end else if (!stall) begin
                r_wb_valid_p1  <= 1'b1;
                r_wb_rd_idx_p1 <= rd_idx;
                r_wb_reg_we_p1 <= reg_we;
                r_wb_data_p1   <= w_wb_data;
            end
            r_exc_adel_p1 <= w_rec & w_is_ld;
            r_exc_ades_p1 <= w_rec & w_is_st;
            if (w_rec) begin
                r_exc_pc_p1    <= pc;
                r_bad_vaddr_p1 <= addr;
            end
        end
    end

    assign wb_valid  = r_wb_valid_p1;
    assign wb_rd_idx = r_wb_rd_idx_p1;
    assign wb_reg_we = r_wb_reg_we_p1;
    assign wb_data   = r_wb_data_p1;
    assign exc_adel  = r_exc_adel_p1;
    assign exc_ades  = r_exc_ades_p1;
    assign exc_pc    = r_exc_pc_p1;
    assign bad_vaddr = r_bad_vaddr_p1;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed test-plan cases plus a random phase.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, flush = 1'b0, interupt = 1'b0;
    logic [3:0]  mem_op = 4'd0;
    logic [31:0] addr = 32'd0, store_data = 32'd0, pc = 32'd0, dm_RD = 32'd0;
    logic [4:0]  rd_idx = 5'd0;
    logic        reg_we = 1'b0;
    logic [29:0] dm_A;
    logic [31:0] dm_WD;
    logic        dm_we;
    logic [3:0]  dm_BE;
    logic        wb_valid, wb_reg_we, exc_adel, exc_ades;
    logic [4:0]  wb_rd_idx;
    logic [31:0] wb_data, exc_pc, bad_vaddr;

    mem_access_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .interupt(interupt),
        .mem_op(mem_op), .addr(addr), .store_data(store_data), .pc(pc),
        .rd_idx(rd_idx), .reg_we(reg_we), .dm_A(dm_A), .dm_WD(dm_WD),
        .dm_we(dm_we), .dm_BE(dm_BE), .dm_RD(dm_RD), .wb_valid(wb_valid),
        .wb_rd_idx(wb_rd_idx), .wb_reg_we(wb_reg_we), .wb_data(wb_data),
        .exc_adel(exc_adel), .exc_ades(exc_ades), .exc_pc(exc_pc), .bad_vaddr(bad_vaddr)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        v;
        bit [4:0]  rd;
        bit        we;
        bit [31:0] d;
        bit        adel;
        bit        ades;
        bit [31:0] epc;
        bit [31:0] bad;
    } exp_t;

    exp_t q[$];
    exp_t m;
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    endtask

    task automatic clear_model();
        m = '{v: 1'b0, rd: 5'd0, we: 1'b0, d: 32'd0, adel: 1'b0, ades: 1'b0, epc: 32'd0, bad: 32'd0};
    endtask

    task automatic chk_regs_zero(input string tag);
        chk({tag, "_valid"}, wb_valid, 0);
        chk({tag, "_rd"}, wb_rd_idx, 0);
        chk({tag, "_rwe"}, wb_reg_we, 0);
        chk({tag, "_data"}, wb_data, 0);
        chk({tag, "_adel"}, exc_adel, 0);
        chk({tag, "_ades"}, exc_ades, 0);
        chk({tag, "_epc"}, exc_pc, 0);
        chk({tag, "_bad"}, bad_vaddr, 0);
    endtask

    // Called just after a rising edge: drives one MEM cycle, checks memory side,
    // queues the predicted WB/exception state and compares it after the next edge.
    task automatic step(input bit [3:0] op, input bit [31:0] a, input bit [31:0] sd,
                        input bit [31:0] rdv, input bit [31:0] p, input bit [4:0] rd,
                        input bit we, input bit stl, input bit fl, input bit it);
        bit [1:0]  off;
        bit        ld, st, mis, rec;
        int        sz;
        bit [3:0]  be;
        bit [31:0] sh, ldv;
        exp_t      e, got;
        mem_op = op; addr = a; store_data = sd; dm_RD = rdv; pc = p;
        rd_idx = rd; reg_we = we; stall = stl; flush = fl; interupt = it;
        off = a[1:0];
        ld  = (op >= 4'd1 && op <= 4'd5);
        st  = (op == 4'd8 || op == 4'd9 || op == 4'd10);
        sz  = (op == 4'd1 || op == 4'd8) ? 4 :
              (op == 4'd2 || op == 4'd3 || op == 4'd9) ? 2 :
              (op == 4'd4 || op == 4'd5 || op == 4'd10) ? 1 : 0;
        mis = (sz == 4 && off != 2'd0) || (sz == 2 && off[0]);
        be  = 4'b0000;
        if (st && !mis) be = (sz == 4) ? 4'hF : (sz == 2) ? (4'b0011 << off) : (4'b0001 << off);
        sh = rdv >> (8 * off);
        case (op)
            4'd1:    ldv = rdv;
            4'd2:    ldv = {{16{sh[15]}}, sh[15:0]};
            4'd3:    ldv = {16'h0000, sh[15:0]};
            4'd4:    ldv = {{24{sh[7]}}, sh[7:0]};
            4'd5:    ldv = {24'h000000, sh[7:0]};
            default: ldv = a;
        endcase
        #1;
        chk("dm_A", {2'b00, dm_A}, a >> 2);
        chk("dm_WD", dm_WD, sd);
        chk("dm_BE", dm_BE, be);
        chk("dm_we", dm_we, st && !mis && !stl && !fl && !it);
        e = m;
        if (fl || it || mis) begin
            e.v = 1'b0; e.we = 1'b0;
        end else if (!stl) begin
            e.v = 1'b1; e.rd = rd; e.we = we; e.d = ldv;
        end
        rec = mis && !fl && !it && !stl;
        e.adel = rec && ld;
        e.ades = rec && st;
        if (rec) begin
            e.epc = p; e.bad = a;
        end
        m = e;
        q.push_back(e);
        @(posedge clk);
        #1;
        got = q.pop_front();
        chk("wb_valid", wb_valid, got.v);
        if (got.v) begin
            chk("wb_rd_idx", wb_rd_idx, got.rd);
            chk("wb_data", wb_data, got.d);
        end
        chk("wb_reg_we", wb_reg_we, got.we);
        chk("exc_adel", exc_adel, got.adel);
        chk("exc_ades", exc_ades, got.ades);
        chk("exc_pc", exc_pc, got.epc);
        chk("bad_vaddr", bad_vaddr, got.bad);
    endtask

    task automatic nop();
        step(4'd0, 32'h0000_0100, 32'd0, 32'd0, 32'h0000_0F00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [3:0] ops [10];
        ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd7};
        clear_model();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_regs_zero("rst0");
        rst = 1'b0;

        // sw then lw of the same word
        step(4'd8, 32'h10, 32'hDEADBEEF, 32'd0, 32'h1000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(4'd1, 32'h10, 32'd0, 32'hDEADBEEF, 32'h1004, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("tp_lw", wb_data, 32'hDEADBEEF);

        // byte store / loads at the top lane
        step(4'd10, 32'h13, 32'h000000AB, 32'd0, 32'h1008, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(4'd4, 32'h13, 32'd0, 32'hAB000000, 32'h100C, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("tp_lb", wb_data, 32'hFFFFFFAB);
        step(4'd5, 32'h13, 32'd0, 32'hAB000000, 32'h1010, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("tp_lbu", wb_data, 32'h000000AB);

        // halfword store / loads at the upper half
        step(4'd9, 32'h22, 32'h00001234, 32'd0, 32'h1014, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(4'd2, 32'h22, 32'd0, 32'h80010000, 32'h1018, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("tp_lh", wb_data, 32'hFFFF8001);
        step(4'd3, 32'h22, 32'd0, 32'h80010000, 32'h101C, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("tp_lhu", wb_data, 32'h00008001);

        // misaligned load and store
        step(4'd1, 32'h21, 32'd0, 32'd0, 32'h3000, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("tp_adel", exc_adel, 1'b1);
        chk("tp_adel_bad", bad_vaddr, 32'h21);
        nop();
        step(4'd9, 32'h23, 32'h5555, 32'd0, 32'h3004, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("tp_ades", exc_ades, 1'b1);
        nop();

        // misaligned op stalled: no pulse until the stall clears, then exactly one
        step(4'd8, 32'h42, 32'h1, 32'd0, 32'h3008, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(4'd8, 32'h42, 32'h1, 32'd0, 32'h3008, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        nop();

        // aligned sw stalled three cycles, then released; then stall+flush
        for (int i = 0; i < 3; i++)
            step(4'd8, 32'h40, 32'h12345678, 32'd0, 32'h2000, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        step(4'd8, 32'h40, 32'h12345678, 32'd0, 32'h2000, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        step(4'd1, 32'h40, 32'd0, 32'h0BADF00D, 32'h2004, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("tp_stall_flush", wb_valid, 1'b0);

        // interrupt blocks a store and a misaligned load's exception
        step(4'd8, 32'h50, 32'hCAFEF00D, 32'd0, 32'h2008, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(4'd1, 32'h51, 32'd0, 32'd0, 32'h200C, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1);

        // random mix
        for (int i = 0; i < 60; i++)
            step(ops[$urandom_range(0, 9)], $urandom, $urandom, $urandom, $urandom,
                 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 9) == 0));

        // asynchronous reset with a valid WB bundle in place
        step(4'd1, 32'h60, 32'd0, 32'h01020304, 32'h4000, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_valid", wb_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk_regs_zero("rst_async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();
        step(4'd5, 32'h61, 32'd0, 32'h0000A500, 32'h4004, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("post_rst_lbu", wb_data, 32'h000000A5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

MEM-stage access unit and MEM/WB pipeline register of the pipelined CPU. It sits directly upstream of the 4 KB data memory:
- drives word address, write data, write enable and byte enables into the data memory;
- takes the memory's combinational read data and performs load lane selection plus sign/zero extension;
- registers the writeback bundle for the WB stage.

It also detects misaligned accesses, suppresses the offending store, and reports a registered address-error exception.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stall  in  1  hold MEM/WB register and block the store this cycle.
- flush  in  1  squash the MEM instruction (bubble into WB).
- interupt  in  1  interrupt taken; squash the MEM instruction and block its store.
- mem_op  in  4  1=lw, 2=lh, 3=lhu, 4=lb, 5=lbu, 8=sw, 9=sh, 10=sb; any other value=no access.
- addr  in  32  effective address / ALU result.
- store_data  in  32  rt value for stores.
- pc  in  32  PC of the MEM instruction.
- rd_idx  in  5  destination register.
- reg_we  in  1  instruction writes a register.
- dm_A  out  30  word address to the data memory; equals addr[31:2].
- dm_WD  out  32  store_data, passed unmodified. Lane placement is done by the memory from WD[15:0] / WD[7:0].
- dm_we  out  1  store strobe.
- dm_BE  out  4  byte enables.
- dm_RD  in  32  combinational read data from the data memory.
- wb_valid  out  1  WB bundle valid.
- wb_rd_idx  out  5  registered destination.
- wb_reg_we  out  1  registered write enable.
- wb_data  out  32  extended load data, or addr for non-loads.
- exc_adel  out  1  one-cycle pulse: load address error.
- exc_ades  out  1  one-cycle pulse: store address error.
- exc_pc  out  32  PC of the faulting instruction; held until the next exception.
- bad_vaddr  out  32  faulting address; held until the next exception.

## Operation
- Offset: off = addr[1:0].
- Misalignment: lw/sw with off≠0; lh/lhu/sh with off[0]=1. Byte ops are never misaligned.
- dm_BE, combinational:
  - sw → 1111.
  - sh → 0011 (off=0) or 1100 (off=2).
  - sb → 0001/0010/0100/1000 for off=0/1/2/3.
  - Non-store or misaligned store → 0000.
  - Only these seven non-zero patterns are ever driven.
- dm_we = store & aligned & !stall & !flush & !interupt.
- Load data, byte/half selected by off:
  - lw → dm_RD.
  - lh/lhu → dm_RD[15:0] (off=0) or [31:16] (off=2), sign-/zero-extended.
  - lb/lbu → byte at dm_RD[8*off+7:8*off], sign-/zero-extended.
- wb_data = extended load for loads, addr otherwise.
- Squash = flush | interupt | misaligned.
- Register update priority per edge: squash > stall > advance.
  - Squash: wb_valid=0, wb_reg_we=0; wb_data and wb_rd_idx don't-care but hold.
  - Stall: all wb_* hold.
  - Advance: wb_valid=1, wb_rd_idx=rd_idx, wb_reg_we=reg_we, wb_data as above.
- Exception recording, only when a misaligned load/store is in MEM with !flush, !interupt, !stall:
  - Next edge: exc_adel or exc_ades pulses 1 for one cycle.
  - exc_pc←pc, bad_vaddr←addr.
  - While stalled, recording waits; exactly one pulse per instruction.

## Timing
- Memory-side outputs are combinational from inputs: a store commits at the same edge the instruction leaves MEM.
- Load result appears on wb_data one edge after the MEM cycle (latency 1).
- Reset (asynchronous, immediate): wb_valid=0, wb_rd_idx=0, wb_reg_we=0, wb_data=0, exc_adel=0, exc_ades=0, exc_pc=0, bad_vaddr=0.
- Combinational outputs during reset follow inputs; the memory ignores them under rst.
- Deassertion of rst mid-operation: the first edge afterwards captures normally.
- Simultaneous events:
  - stall+flush → flush wins.
  - interupt with misaligned op → no exception pulse, no store.
  - Back-to-back exceptions overwrite exc_pc and bad_vaddr.

## Test plan
- sw addr=0x10, store_data=0xDEADBEEF → dm_BE=1111, dm_we=1, dm_A=0x4; next-cycle lw 0x10 with dm_RD=0xDEADBEEF → wb_data=0xDEADBEEF, wb_valid=1.
- sb addr=0x13, store_data=0x000000AB → dm_BE=1000, dm_WD=0x000000AB; lb 0x13 with dm_RD=0xAB000000 → wb_data=0xFFFFFFAB; lbu 0x13 → wb_data=0x000000AB.
- sh addr=0x22 → dm_BE=1100; lh 0x22 with dm_RD=0x8001_0000 → wb_data=0xFFFF8001; lhu 0x22 → wb_data=0x00008001.
- lw addr=0x21, pc=0x3000 → next edge exc_adel=1 for one cycle, bad_vaddr=0x21, exc_pc=0x3000, wb_valid=0. sh addr=0x23 → dm_we=0, exc_ades pulse.
- sw aligned with stall=1 for 3 cycles → dm_we=0 and wb_* held; stall drops → dm_we=1 for exactly one cycle. stall=1 with flush=1 → wb_valid=0.
- Assert rst mid-stream with wb_valid=1 → all registered outputs 0 immediately (before the next clk edge); sw with interupt=1 → dm_we=0, wb_valid=0 next edge.
